// File: rtl/music_playlist_ctrl.sv
// Playlist scheduler: queues song numbers and launches each one on the player when it is idle.
// Build with PLAYLIST_LOOP_EN defined to add the `loop` input (launched songs re-queue at the tail).
module music_playlist_ctrl #(
  parameter int DEPTH         = 8,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_val,
  input  logic [4:0]               enq_song,
  output logic                     enq_rdy,
  input  logic                     flush,
  input  logic                     run,
`ifdef PLAYLIST_LOOP_EN
  input  logic                     loop,
`endif
  input  logic                     player_idle,
  output logic [4:0]               song_sel,
  output logic                     start_song,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               songs_played,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    PLAY      = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [4:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [4:0]      r_song_sel;
  logic [7:0]      r_songs_played;
  logic            r_timeout_err;
  logic [TW-1:0]   r_wait_cnt;

  logic            w_launch;
  logic            w_timeout;
  logic            w_song_done;
  logic            w_pop;
  logic            w_push;
  logic            w_loop_wr;
  logic            w_wr_en;
  logic [4:0]      w_wr_dat;

  // Guard on count keeps a flush racing the IDLE->START edge from popping an empty FIFO.
  assign w_pop = (r_state == START) && (r_count != '0);

`ifdef PLAYLIST_LOOP_EN
  assign w_loop_wr = w_pop && loop;
`else
  assign w_loop_wr = 1'b0;
`endif

  // Uses the pre-pop count, so a full FIFO refuses pushes even in the START cycle.
  assign enq_rdy  = (r_count < CW'(DEPTH)) && !flush && !w_loop_wr;
  assign w_push   = enq_val && enq_rdy;
  assign w_wr_en  = (w_push || w_loop_wr) && !flush;
  assign w_wr_dat = w_loop_wr ? r_song_sel : enq_song;

  always_comb begin
    w_next      = r_state;
    w_timeout   = 1'b0;
    w_song_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (run && (r_count != '0) && player_idle) begin
          w_next = START;
        end
      end
      START: begin
        w_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!player_idle) begin
          w_next = PLAY;
        end else if (r_wait_cnt == TW'(START_TIMEOUT - 1)) begin
          w_next    = IDLE;
          w_timeout = 1'b1;
        end
      end
      PLAY: begin
        if (player_idle) begin
          w_next      = IDLE;
          w_song_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_launch = (r_state == IDLE) && (w_next == START);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The head is captured on the edge into START so song_sel is valid during the pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_song_sel     <= '0;
      r_songs_played <= '0;
      r_timeout_err  <= 1'b0;
      r_wait_cnt     <= '0;
    end else begin
      if (w_launch) begin
        r_song_sel <= r_mem[r_rd_ptr];
      end
      if (w_song_done) begin
        r_songs_played <= r_songs_played + 8'd1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
      if (r_state == WAIT_BUSY && player_idle) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  assign song_sel     = r_song_sel;
  assign start_song   = (r_state == START);
  assign state        = r_state;
  assign count        = r_count;
  assign songs_played = r_songs_played;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_music_playlist_ctrl.sv
// Directed bench for music_playlist_ctrl with a simple player model and a launch log.
module tb_music_playlist_ctrl;

  logic       clk;
  logic       rst;
  logic       enq_val;
  logic [4:0] enq_song;
  logic       enq_rdy;
  logic       flush;
  logic       run;
  logic       loop;
  logic       player_idle;
  logic [4:0] song_sel;
  logic       start_song;
  logic [1:0] state;
  logic [3:0] count;
  logic [7:0] songs_played;
  logic       timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int busy = 0;
  int play_len = 5;
  int hang_song = 99;
  int n0;
  logic [4:0] launched [$];

  music_playlist_ctrl #(.DEPTH(8), .START_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_val      (enq_val),
    .enq_song     (enq_song),
    .enq_rdy      (enq_rdy),
    .flush        (flush),
    .run          (run),
`ifdef PLAYLIST_LOOP_EN
    .loop         (loop),
`endif
    .player_idle  (player_idle),
    .song_sel     (song_sel),
    .start_song   (start_song),
    .state        (state),
    .count        (count),
    .songs_played (songs_played),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Player model: updates 2ns after each rising edge, logs every start pulse.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        busy = 0;
      end else if (start_song) begin
        launched.push_back(song_sel);
        if (int'(song_sel) != hang_song) busy = play_len;
      end else if (busy > 0) begin
        busy--;
      end
      player_idle = (busy == 0);
    end
  end

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int s);
    enq_val  = 1'b1;
    enq_song = 5'(s);
    @(negedge clk);
    enq_val  = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim, input string tag);
    for (int i = 0; i < lim; i++) begin
      if (int'(state) == s) break;
      @(negedge clk);
    end
    check(tag, state, s);
  endtask

  task automatic wait_quiet(input string tag);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (state == 2'd0 && count == 4'd0 && busy == 0) break;
    end
    check(tag, {state, count}, 0);
  endtask

  initial begin
    rst = 1'b0; enq_val = 1'b0; enq_song = '0; flush = 1'b0;
    run = 1'b0; loop = 1'b0; player_idle = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_count", count, 0);
    check("rst_sel", song_sel, 0);
    check("rst_start", start_song, 0);
    check("rst_played", songs_played, 0);
    check("rst_terr", timeout_err, 0);
    rst = 1'b1;
    #1 check("rst_rdy", enq_rdy, 1);

    // Push 3, 7, 12 back to back; first launch one cycle after the push edge
    @(negedge clk);
    run = 1'b1; play_len = 5;
    enq_val = 1'b1; enq_song = 5'd3;
    @(negedge clk);
    check("lat_count", count, 1);
    check("lat_idle", state, 0);
    enq_song = 5'd7;
    @(negedge clk);
    check("lat_start", start_song, 1);
    check("lat_sel", song_sel, 3);
    check("lat_count2", count, 2);
    enq_song = 5'd12;
    @(negedge clk);
    check("pushpop_count", count, 2);
    enq_val = 1'b0;
    wait_quiet("t1_quiet");
    check("t1_n", launched.size(), 3);
    check("t1_s0", launched[0], 3);
    check("t1_s1", launched[1], 7);
    check("t1_s2", launched[2], 12);
    check("t1_played", songs_played, 3);

    // Fill to DEPTH with run held low; ninth push refused
    run = 1'b0;
    launched.delete();
    enq_val = 1'b1;
    for (int i = 0; i < 9; i++) begin
      enq_song = 5'(20 + i);
      if (i == 8) check("full_rdy", enq_rdy, 0);
      @(negedge clk);
    end
    enq_val = 1'b0;
    check("full_count", count, 8);
    run = 1'b1;
    wait_quiet("t2_quiet");
    check("t2_n", launched.size(), 8);
    for (int i = 0; i < 8; i++) check("t2_order", launched[i], 20 + i);
    check("t2_played", songs_played, 11);

    // Start timeout on song 5, then song 6 launches
    run = 1'b0;
    push(5);
    push(6);
    hang_song = 5;
    run = 1'b1;
    wait_state(2, 20, "to_enter");
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      check("to_pending", timeout_err, 0);
      check("to_wait", state, 2);
    end
    @(negedge clk);
    check("to_set", timeout_err, 1);
    check("to_idle", state, 0);
    check("to_played", songs_played, 11);
    hang_song = 99;
    wait_quiet("t3_quiet");
    check("to_next", launched[launched.size() - 1], 6);
    check("to_played2", songs_played, 12);
    check("to_sticky", timeout_err, 1);

    // run=0 holds launches; a started song completes after run drops
    run = 1'b0;
    n0 = launched.size();
    push(1);
    push(2);
    repeat (10) @(negedge clk);
    check("hold_n", launched.size(), n0);
    check("hold_count", count, 2);
    check("hold_state", state, 0);
    run = 1'b1;
    @(negedge clk);
    check("run_start", start_song, 1);
    check("run_sel", song_sel, 1);
    run = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (songs_played == 8'd13) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("hold2_played", songs_played, 13);
    check("hold2_count", count, 1);
    check("hold2_n", launched.size(), n0 + 1);
    run = 1'b1;
    wait_quiet("t4_quiet");
    check("t4_played", songs_played, 14);

    // Flush during PLAY with 4 queued
    run = 1'b0;
    play_len = 20;
    n0 = launched.size();
    for (int i = 0; i < 5; i++) push(30 + i);
    run = 1'b1;
    wait_state(3, 20, "fl_play");
    check("fl_pre", count, 4);
    flush = 1'b1;
    #1 check("fl_rdy", enq_rdy, 0);
    @(negedge clk);
    flush = 1'b0;
    check("fl_count", count, 0);
    check("fl_state", state, 3);
    wait_state(0, 40, "fl_done");
    repeat (5) @(negedge clk);
    check("fl_played", songs_played, 15);
    check("fl_rest", state, 0);
    check("fl_n", launched.size(), n0 + 1);

    // Reset mid-song
    push(17);
    wait_state(3, 20, "mr_play");
    rst = 1'b0;
    @(negedge clk);
    check("mr_state", state, 0);
    check("mr_count", count, 0);
    check("mr_sel", song_sel, 0);
    check("mr_start", start_song, 0);
    check("mr_played", songs_played, 0);
    check("mr_terr", timeout_err, 0);
    rst = 1'b1;
    #1 check("mr_rdy", enq_rdy, 1);
    @(negedge clk);

`ifdef PLAYLIST_LOOP_EN
    // Looped playlist repeats 1, 2, 1, 2
    run = 1'b0;
    play_len = 3;
    loop = 1'b1;
    push(1);
    push(2);
    n0 = launched.size();
    run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (launched.size() >= n0 + 4) break;
      @(negedge clk);
      if (start_song) check("loop_count", count, 2);
    end
    for (int k = 0; k < 4; k++) check("loop_seq", launched[n0 + k], (k % 2 == 0) ? 1 : 2);
    loop = 1'b0;
    wait_quiet("loop_quiet");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/music_playlist_ctrl.md
# music_playlist_ctrl

Playlist scheduler that sits in front of the music player top level and drives its `song_sel`/`start_song` inputs. Software or a button front-end pushes song numbers into an internal FIFO. The controller launches each queued song when the player is idle, waits for it to finish, then launches the next. It provides run/hold control, flush, a start-acknowledge timeout, and a compile-time repeat-playlist mode.

## Interface
- `DEPTH`, default 8: playlist FIFO entries; power of two, 2..32.
- `START_TIMEOUT`, default 16: cycles to wait for the player to leave idle after a start pulse; must be at least 2.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-low. State resets when `rst`==0 at a rising `clk` edge.
- `enq_val` in 1: push request.
- `enq_song` in 5: song number to push.
- `enq_rdy` out 1: the FIFO accepts a push this cycle.
- `flush` in 1: discard all queued entries.
- `run` in 1: 1 allows new songs to launch; 0 holds between songs.
- `player_idle` in 1: the `idle` output of the music player.
- `song_sel` out 5: song number presented to the player.
- `start_song` out 1: one-cycle start pulse to the player.
- `state` out 2: FSM state, encoded IDLE=0, START=1, WAIT_BUSY=2, PLAY=3.
- `count` out $clog2(DEPTH)+1: number of queued entries.
- `songs_played` out 8: completed-song counter; wraps 255→0.
- `timeout_err` out 1: sticky flag; set on a start timeout.
- `loop` in 1: present only with `PLAYLIST_LOOP_EN` defined.

## Operation
- FIFO: circular buffer with read pointer, write pointer and `count`.
  - `enq_rdy` = (`count` < DEPTH) && !`flush`.
  - A push occurs when `enq_val` && `enq_rdy`.
- IDLE:
  - Go to START when `run` && `count`>0 && `player_idle`.
  - Otherwise stay in IDLE.
- START (exactly 1 cycle):
  - `start_song`=1 and `song_sel` = FIFO head.
  - Pop the head and register it into `song_sel`.
  - Go to WAIT_BUSY.
- WAIT_BUSY:
  - If `player_idle`==0, go to PLAY.
  - Else, after START_TIMEOUT cycles in this state: set `timeout_err`, increment nothing, go to IDLE.
- PLAY:
  - When `player_idle`==1: increment `songs_played`, go to IDLE.
- `song_sel` holds the last launched song until the next START.
- `run`=0 only blocks the IDLE→START transition. A song already started always runs to completion.
- `flush`:
  - Takes priority over push and pop.
  - Clears the pointers and `count` to 0 in the same cycle.
  - Does not change FSM state. A song in progress finishes normally, and the controller then rests in IDLE.
  - A push in a flush cycle is dropped (`enq_rdy`=0).
- Simultaneous push and pop (START cycle): both happen, so `count` is unchanged. A push is allowed when the FIFO is full in this cycle? No: `enq_rdy` uses the pre-pop `count`, so a full FIFO refuses pushes in the START cycle.
- Pointers wrap modulo DEPTH.
- Reset values:
  - `state`=IDLE, `count`=0, pointers=0.
  - `song_sel`=0, `start_song`=0, `songs_played`=0, `timeout_err`=0.
  - `enq_rdy` reads 1 while out of reset.
- Reset mid-song: the controller returns to IDLE with an empty FIFO. It does not wait for the player; the player is reset by the same `rst`.
- `timeout_err` clears only on reset.

## Timing
- Push→launch latency, FIFO empty, `run`=1, player idle:
  - Push accepted at edge N.
  - `count`=1 after edge N.
  - START occupies cycle N+1, so `start_song` is high between edges N+1 and N+2.
- `start_song` and `song_sel` are registered (driven from state/registers, no input-to-output combinational path). `enq_rdy` is combinational from `count` and `flush`.
- Back-to-back songs: after the PLAY→IDLE edge, the next START follows one cycle later. This leaves a minimum of 1 IDLE cycle between a song end and the next start pulse.
- Timeout: the WAIT_BUSY→IDLE transition occurs on the START_TIMEOUT-th edge spent in WAIT_BUSY with `player_idle`=1.

## Configuration
- `PLAYLIST_LOOP_EN` defined:
  - Input `loop` exists.
  - In START with `loop`=1, the popped song is written back at the tail in the same cycle, so `count` is unchanged and the playlist repeats indefinitely.
  - `enq_rdy` is forced to 0 during a looped START.
  - `flush` still empties the FIFO.
- `PLAYLIST_LOOP_EN` undefined: the `loop` port is absent and every launched song leaves the FIFO permanently.

## Test plan
- Reset, then push songs 3, 7, 12 while the player model idles 5 cycles after each start → `start_song` pulses carry `song_sel` 3, 7, 12 in order; `songs_played`=3; `count`=0; `state`=IDLE.
- Push DEPTH=8 entries and hold `enq_val` → `enq_rdy`=0 with `count`=8. A ninth push is rejected and does not appear in playback order.
- Player model never drops idle after the start of song 5 → `timeout_err`=1 exactly 16 cycles after WAIT_BUSY entry, `songs_played` unchanged, and the next queued song launches.
- `run`=0 with 2 songs queued → no `start_song` pulse. Raise `run` → song 1 starts the next cycle. Drop `run` mid-song → the song completes and song 2 waits.
- `flush` during PLAY with 4 queued → `count`=0 next cycle, the current song finishes, `songs_played` increments, and the controller remains in IDLE. Drive `rst`=0 mid-song → all outputs return to their reset values after one edge.
- `PLAYLIST_LOOP_EN` defined, `loop`=1, songs 1, 2 queued → the start sequence is 1, 2, 1, 2, … with `count` constant at 2.
